// File: rtl/vend_dispense_arbiter.sv
// ---------------------------------------------------------------------------
// vend_dispense_arbiter
//
// Shares one dispense motor and one change hopper between four vending
// front-ends. A round-robin grant picks one requester. The FSM then runs
// the motor until the drop sensor fires, pays out the latched change one
// coin per two cycles, and gives a one-cycle done pulse to the winner.
//
// Optional feature (macro VEND_ARB_TIMEOUT_EN):
//   If this macro is defined, an 8-bit counter bounds DISPENSE to
//   TIMEOUT_CYC cycles. On expiry the arbiter pulses err, skips the change
//   payout and still completes through DONE. If the macro is undefined,
//   err is tied low and no counter is built.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active low
//   req[3:0]    in   per-front-end request, held until done[i]
//   chg[11:0]   in   change owed, chg[3i+2:3i] for requester i
//   drop_sense  in   item-drop sensor
//   gnt[3:0]    out  one-hot grant, zero when idle
//   motor_en    out  dispense motor drive
//   coin_pulse  out  change hopper, one high cycle per coin
//   done[3:0]   out  one-cycle completion pulse to the winner
//   busy        out  high in every state except IDLE
//   err         out  one-cycle dispense-timeout pulse
// ---------------------------------------------------------------------------
module vend_dispense_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [11:0] chg,
  input  logic        drop_sense,
  output logic [3:0]  gnt,
  output logic        motor_en,
  output logic        coin_pulse,
  output logic [3:0]  done,
  output logic        busy,
  output logic        err
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be within 2..255");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPENSE = 2'd1,
    S_CHANGE   = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  win_q, win_d;
  logic [2:0]  coin_cnt_q, coin_cnt_d;
  logic        phase_q, phase_d;      // 0 = coin high cycle, 1 = gap cycle
  logic        armed_q;               // blocks a grant on the first edge after reset
  logic        tmo_expire;

  logic        rr_found;
  logic [1:0]  rr_pick;
  logic [1:0]  rr_idx;
  logic [2:0]  chg_sel;
  logic        grant;

`ifdef VEND_ARB_TIMEOUT_EN
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        tmo_hit_q, tmo_hit_d;

  // A drop on the final cycle wins over the timeout.
  assign tmo_expire = (state_q == S_DISPENSE) && !drop_sense &&
                      (tmo_cnt_q == 8'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_cnt_d = (state_q == S_DISPENSE) ? tmo_cnt_q + 8'd1 : 8'd0;
    tmo_hit_d = tmo_expire;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= 8'd0;
      tmo_hit_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_hit_q <= tmo_hit_d;
    end
  end

  // tmo_hit_q is only ever set on the transition into DONE.
  assign err = tmo_hit_q;
`else
  assign tmo_expire = 1'b0;
  assign err        = 1'b0;
`endif

  // Round-robin search: the first requester at or after ptr wins.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = ptr_q;
    rr_idx   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      rr_idx = ptr_q + 2'(k);
      if (!rr_found && req[rr_idx]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  always_comb begin
    case (rr_pick)
      2'd0:    chg_sel = chg[2:0];
      2'd1:    chg_sel = chg[5:3];
      2'd2:    chg_sel = chg[8:6];
      default: chg_sel = chg[11:9];
    endcase
  end

  assign grant = (state_q == S_IDLE) && armed_q && rr_found;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant) state_d = S_DISPENSE;
      end
      S_DISPENSE: begin
        if (drop_sense)      state_d = (coin_cnt_q != 3'd0) ? S_CHANGE : S_DONE;
        else if (tmo_expire) state_d = S_DONE;
      end
      S_CHANGE: begin
        // Leave only after the gap cycle that follows the last coin.
        if (phase_q && coin_cnt_q == 3'd0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    ptr_d      = ptr_q;
    win_d      = win_q;
    coin_cnt_d = coin_cnt_q;
    phase_d    = phase_q;
    if (grant) begin
      win_d      = rr_pick;
      coin_cnt_d = chg_sel;
    end
    if (state_q == S_DISPENSE) phase_d = 1'b0;
    if (state_q == S_CHANGE) begin
      phase_d = ~phase_q;
      if (!phase_q) coin_cnt_d = coin_cnt_q - 3'd1;
    end
    if (state_d == S_DONE && state_q != S_DONE) ptr_d = win_q + 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q      <= 2'd0;
      win_q      <= 2'd0;
      coin_cnt_q <= 3'd0;
      phase_q    <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      coin_cnt_q <= coin_cnt_d;
      phase_q    <= phase_d;
      armed_q    <= 1'b1;
    end
  end

  // Output decode from registered state
  always_comb begin
    gnt        = 4'b0000;
    motor_en   = 1'b0;
    coin_pulse = 1'b0;
    done       = 4'b0000;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_DISPENSE: begin
        gnt      = 4'b0001 << win_q;
        motor_en = 1'b1;
      end
      S_CHANGE: begin
        gnt        = 4'b0001 << win_q;
        coin_pulse = ~phase_q;
      end
      S_DONE: begin
        gnt  = 4'b0001 << win_q;
        done = 4'b0001 << win_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vend_dispense_arbiter.sv
module tb_vend_dispense_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] chg;
  logic        drop_sense;
  logic [3:0]  gnt;
  logic        motor_en;
  logic        coin_pulse;
  logic [3:0]  done;
  logic        busy;
  logic        err;

  int n_checks = 0;
  int n_pass   = 0;

  vend_dispense_arbiter #(.TIMEOUT_CYC(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .chg        (chg),
    .drop_sense (drop_sense),
    .gnt        (gnt),
    .motor_en   (motor_en),
    .coin_pulse (coin_pulse),
    .done       (done),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    int mcnt;
    int coin_seen;

    rst = 1'b0; req = 4'b0000; chg = 12'h000; drop_sense = 1'b0;
    #3;
    chk("rst_gnt",   32'(gnt), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_motor", 32'(motor_en), 0);
    chk("rst_coin",  32'(coin_pulse), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_err",   32'(err), 0);
    step(); step();

    // Requester 0, no change, drop on the third DISPENSE cycle
    req = 4'b0001;
    rst = 1'b1;
    step();
    chk("first_edge_no_gnt", 32'(gnt), 0);
    step();
    chk("t1_gnt_c1",   32'(gnt), 32'h1);
    chk("t1_motor_c1", 32'(motor_en), 1);
    step();
    chk("t1_motor_c2", 32'(motor_en), 1);
    step();
    chk("t1_motor_c3", 32'(motor_en), 1);
    drop_sense = 1'b1;
    step();
    drop_sense = 1'b0;
    req = 4'b0000;
    chk("t1_done",     32'(done), 32'h1);
    chk("t1_gnt_done", 32'(gnt), 32'h1);
    chk("t1_motor_off",32'(motor_en), 0);
    step();
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_gnt",  32'(gnt), 0);
    chk("t1_idle_done", 32'(done), 0);

    // Requester 1 with three coins of change
    req = 4'b0010;
    chg = 12'h018;
    step();
    chk("t2_gnt",  32'(gnt), 32'h2);
    chk("t2_coin0",32'(coin_pulse), 0);
    chg = 12'h000;
    drop_sense = 1'b1;
    step();
    drop_sense = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      chk("t2_coin_seq", 32'(coin_pulse), (i % 2 == 0) ? 1 : 0);
      pulses += int'(coin_pulse);
      step();
    end
    chk("t2_pulses",   32'(pulses), 3);
    chk("t2_done",     32'(done), 32'h2);
    chk("t2_coin_end", 32'(coin_pulse), 0);
    req = 4'b0000;
    step();
    chk("t2_idle", 32'(busy), 0);

    // Requester 2, reset during CHANGE with two coins left
    req = 4'b0100;
    chg = 12'h100;
    step();
    chk("t3_gnt", 32'(gnt), 32'h4);
    drop_sense = 1'b1;
    step();
    drop_sense = 1'b0;
    chk("t3_coin_c1", 32'(coin_pulse), 1);
    step(); step(); step(); step();
    chk("t3_coin_c5", 32'(coin_pulse), 1);
    rst = 1'b0;
    #1;
    chk("t3_rst_coin",  32'(coin_pulse), 0);
    chk("t3_rst_gnt",   32'(gnt), 0);
    chk("t3_rst_busy",  32'(busy), 0);
    chk("t3_rst_motor", 32'(motor_en), 0);
    step();
    chk("t3_rst_done_a", 32'(done), 0);
    step();
    chk("t3_rst_done_b", 32'(done), 0);

    // All four held, instant drops: order 0,1,2,3,0 starting from ptr 0
    req = 4'b1111;
    chg = 12'h000;
    drop_sense = 1'b1;
    rst = 1'b1;
    step();
    chk("t4_first_edge", 32'(gnt), 0);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t4_gnt",  32'(gnt), 32'(1 << (i % 4)));
      step();
      chk("t4_done", 32'(done), 32'(1 << (i % 4)));
      step();
      chk("t4_idle_gap", 32'(busy), 0);
      if (i < 4) step();
    end
    req = 4'b0000;
    drop_sense = 1'b0;
    step();

    // Requester 2 drops its request mid-service; other bits rise meanwhile
    req = 4'b0100;
    step();
    chk("t5_gnt", 32'(gnt), 32'h4);
    req = 4'b1011;
    step();
    chk("t5_gnt_held", 32'(gnt), 32'h4);
    chk("t5_motor",    32'(motor_en), 1);
    drop_sense = 1'b1;
    step();
    drop_sense = 1'b0;
    chk("t5_done", 32'(done), 32'h4);
    step();
    chk("t5_idle", 32'(busy), 0);
    step();
    chk("t5_next_gnt", 32'(gnt), 32'h8);
    drop_sense = 1'b1;
    step();
    req = 4'b0000;
    drop_sense = 1'b0;
    step();
    chk("t5_end_idle", 32'(busy), 0);

`ifdef VEND_ARB_TIMEOUT_EN
    // No drop: timeout after 16 motor cycles, change skipped
    req = 4'b0001;
    chg = 12'h005;
    step();
    mcnt = 0;
    coin_seen = 0;
    for (int i = 0; i < 40 && motor_en; i++) begin
      mcnt++;
      if (coin_pulse) coin_seen = 1;
      step();
    end
    chk("t6_motor_cycles", 32'(mcnt), 16);
    chk("t6_err",          32'(err), 1);
    chk("t6_done",         32'(done), 32'h1);
    chk("t6_no_coin",      32'(coin_seen | int'(coin_pulse)), 0);
    req = 4'b0000;
    step();
    chk("t6_err_clear", 32'(err), 0);
    chk("t6_idle",      32'(busy), 0);
`else
    mcnt = 0;
    coin_seen = 0;
    chk("err_tied_low", 32'(err), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/vend_dispense_arbiter.md
VEND_DISPENSE_ARBITER -- requirements
Module: vend_dispense_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, is the maximum cycles motor_en stays high waiting for drop_sense; legal range 2..255.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-front-end dispense request; bit i is held by front-end i until done[i].
REQ-005 chg  input  12  change coins owed; chg[3i+2:3i] belongs to requester i, range 0..7, sampled only at grant.
REQ-006 drop_sense  input  1  item-drop sensor; high for at least 1 cycle when an item falls.
REQ-007 gnt  output  4  one-hot grant; all-zero when idle.
REQ-008 motor_en  output  1  shared dispense motor drive.
REQ-009 coin_pulse  output  1  shared change hopper; one high cycle per coin returned.
REQ-010 done  output  4  one-cycle completion pulse to the granted requester.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 err  output  1  one-cycle pulse on dispense timeout.

Function
REQ-013 FSM states SHALL be IDLE, DISPENSE, CHANGE and DONE, registered, with all outputs decoded from registered state.
REQ-014 IDLE: when req!=0, select winner round-robin starting from ptr, latch its 3-bit chg into coin_cnt, and go to DISPENSE next cycle.
REQ-015 Latency: req sampled high in IDLE at edge t gives gnt[i]=1 and motor_en=1 from edge t+1.
REQ-016 ptr resets to 0 and updates to (winner+1) mod 4 on entry to DONE, so each requester waits at most 3 services.
REQ-017 DISPENSE: motor_en=1 and gnt held; on drop_sense=1 go to CHANGE if coin_cnt>0, else go to DONE.
REQ-018 CHANGE: coin_pulse alternates high/low starting high, and coin_cnt decrements on each high cycle.
REQ-019 CHANGE: after the low cycle that follows the last pulse (coin_cnt=0), go to DONE; N coins take exactly 2N cycles.
REQ-020 DONE: one cycle long; done[winner]=1 and gnt still asserted; next state is IDLE, and gnt clears on exit.
REQ-021 After DONE, IDLE lasts at least one cycle before the next grant, even when req is pending.
REQ-022 req[winner] dropping mid-service SHALL NOT abort the service; other req bits are ignored while busy.
REQ-023 drop_sense outside DISPENSE SHALL be ignored.
REQ-024 gnt, motor_en and coin_pulse SHALL never be high while busy=0.

Reset
REQ-025 rst=0 forces asynchronously: state IDLE, ptr=0, coin_cnt=0, gnt=0, motor_en=0, coin_pulse=0, done=0, busy=0, err=0, timeout counter=0.
REQ-026 Reset mid-DISPENSE or mid-CHANGE drops motor_en and coin_pulse immediately, and the interrupted requester gets no done pulse.
REQ-027 After rst rises, the first grant occurs no earlier than the second rising clk edge.

Configuration
REQ-028 Macro VEND_ARB_TIMEOUT_EN, when defined, SHALL add an 8-bit cycle counter in DISPENSE.
REQ-029 With VEND_ARB_TIMEOUT_EN defined: if drop_sense is absent for TIMEOUT_CYC cycles, pulse err for one cycle, skip CHANGE and go to DONE, with done still pulsed.
REQ-030 With VEND_ARB_TIMEOUT_EN undefined: DISPENSE waits indefinitely, err is tied 0 and no counter is synthesized.

Verification
REQ-031 req=0001, chg[2:0]=0, drop_sense at 3rd DISPENSE cycle -> gnt=0001 and motor_en for 3 cycles, then done=0001 for 1 cycle, then IDLE.
REQ-032 req=0010, chg[5:3]=3 -> after drop, exactly 3 coin_pulse highs in 6 cycles, then done=0010.
REQ-033 req=1111 held, instant drops, chg=0 -> grant order 0,1,2,3,0, with one IDLE cycle between services.
REQ-034 With VEND_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, no drop_sense -> motor_en for 16 cycles, then err=1 and done for the same cycle, and no coin_pulse.
REQ-035 rst asserted during CHANGE with 2 coins left -> coin_pulse=0 and gnt=0 immediately, no done; after release, a pending req is granted starting from ptr=0.
REQ-036 req[2] dropped during DISPENSE -> service completes and done[2] still pulses.
